// File: rtl/reset_release_seq.sv
// Reset release sequencer: asserts all outputs asynchronously, then releases them
// one by one in bit order after a synchronised deassertion and a hold period.
module reset_release_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned NUM_OUT     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_e;

  // One counter serves both the hold period and the inter-release gap.
  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [NUM_OUT-1:0] AllOnes  = '1;
  localparam logic [NUM_OUT-1:0] FirstRel = AllOnes << 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rel;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_OUT-1:0]  rst_q, rst_d;
  logic                ready_q, ready_d;
  logic [NUM_OUT-1:0]  shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rel = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Bit 0 releases first, so each release shifts a zero in from the bottom.
  assign shifted = rst_q << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    unique case (state_q)
      StAssert: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (sync_rel) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          cnt_d = '0;
          rst_d = FirstRel;
          if (FirstRel == '0) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (soft_req) begin
          state_d = StHold;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end else if (cnt_q == GapLast) begin
          cnt_d = '0;
          rst_d = shifted;
          if (shifted == '0) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (soft_req) begin
          state_d = StHold;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = StAssert;
        cnt_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign rst_out = rst_q;
  assign ready   = ready_q;
  assign state   = state_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Bench for reset_release_seq: edge-count model of the release schedule plus
// directed timing checks on a default instance and a minimal one-output instance.
`timescale 1ns/1ps
module tb_reset_release_seq;

  localparam int S0 = 2, H0 = 4, G0 = 2, N0 = 3;
  localparam int S1 = 2, H1 = 1, G1 = 1, N1 = 1;

  logic       clk;
  logic       reset;
  logic       soft_req;
  logic       soft1;
  logic [2:0] rst_out;
  logic       ready;
  logic [1:0] state;
  logic [0:0] rst_out1;
  logic       ready1;
  logic [1:0] state1;

  int tests = 0;
  int fails = 0;
  int n0 = 0;
  int n1 = 0;

  reset_release_seq #(
    .SYNC_STAGES(S0), .HOLD_CYCLES(H0), .GAP_CYCLES(G0), .NUM_OUT(N0)
  ) dut (
    .clk(clk), .reset(reset), .soft_req(soft_req),
    .rst_out(rst_out), .ready(ready), .state(state)
  );

  reset_release_seq #(
    .SYNC_STAGES(S1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1), .NUM_OUT(N1)
  ) dut1 (
    .clk(clk), .reset(reset), .soft_req(soft1),
    .rst_out(rst_out1), .ready(ready1), .state(state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: n counts edges since reset fell; a restart rewinds n to the HOLD entry point.
  function automatic void model(input int n, input int ss, input int hc, input int gc,
                                input int no, output logic [7:0] r, output logic rdy,
                                output logic [1:0] st);
    int last;
    last = ss + 1 + hc + (no - 1) * gc;
    r = '0;
    for (int k = 0; k < no; k++) r[k] = (n < ss + 1 + hc + k * gc);
    rdy = (n >= last);
    if (n < ss + 1) st = 2'd0;
    else if (n < ss + 1 + hc) st = 2'd1;
    else if (n < last) st = 2'd2;
    else st = 2'd3;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n0 <= 0;
      n1 <= 0;
    end else begin
      if (soft_req && n0 >= S0 + 1) n0 <= S0 + 1;
      else if (n0 < 1000) n0 <= n0 + 1;
      if (soft1 && n1 >= S1 + 1) n1 <= S1 + 1;
      else if (n1 < 1000) n1 <= n1 + 1;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] er;
    logic       erdy;
    logic [1:0] est;
    model(n0, S0, H0, G0, N0, er, erdy, est);
    chk("m0_rst_out", {5'd0, rst_out}, er);
    chk("m0_ready", {7'd0, ready}, {7'd0, erdy});
    chk("m0_state", {6'd0, state}, {6'd0, est});
    chk("m0_order", {7'd0, ((!rst_out[1] && rst_out[0]) || (!rst_out[2] && rst_out[1]))}, 8'd0);
    model(n1, S1, H1, G1, N1, er, erdy, est);
    chk("m1_rst_out", {7'd0, rst_out1}, er);
    chk("m1_ready", {7'd0, ready1}, {7'd0, erdy});
    chk("m1_state", {6'd0, state1}, {6'd0, est});
  end

  task automatic at(input realtime t);
    #(t - $realtime);
  endtask

  initial begin
    reset = 1'b0;
    soft_req = 1'b0;
    soft1 = 1'b0;
    #1 reset = 1'b1;
    at(30);    chk("rst_hold_out", {5'd0, rst_out}, 8'h07);
               chk("rst_hold_rdy", {7'd0, ready}, 8'h00);
               chk("rst_hold_st", {6'd0, state}, 8'h00);
    at(33);    reset = 1'b0;
    at(64);    chk("n1_pre_out", {7'd0, rst_out1}, 8'h01);
               chk("n1_pre_rdy", {7'd0, ready1}, 8'h00);
    at(66);    chk("n1_post_out", {7'd0, rst_out1}, 8'h00);
               chk("n1_post_rdy", {7'd0, ready1}, 8'h01);
    at(94);    chk("b0_pre", {5'd0, rst_out}, 8'h07);
    at(96);    chk("b0_post", {5'd0, rst_out}, 8'h06);
    at(114);   chk("b1_pre", {5'd0, rst_out}, 8'h06);
    at(116);   chk("b1_post", {5'd0, rst_out}, 8'h04);
    at(134);   chk("rdy_pre", {7'd0, ready}, 8'h00);
    at(136);   chk("run_out", {5'd0, rst_out}, 8'h00);
               chk("run_rdy", {7'd0, ready}, 8'h01);
               chk("run_st", {6'd0, state}, 8'h03);
    at(143);   reset = 1'b1;
    at(143.5); chk("async_out", {5'd0, rst_out}, 8'h07);
               chk("async_rdy", {7'd0, ready}, 8'h00);
               chk("async_st", {6'd0, state}, 8'h00);
               chk("async_n1_out", {7'd0, rst_out1}, 8'h01);
    at(163);   reset = 1'b0;
    at(201);   reset = 1'b1;
    at(201.5); chk("pulse_out", {5'd0, rst_out}, 8'h07);
               chk("pulse_st", {6'd0, state}, 8'h00);
    at(203);   reset = 1'b0;
    at(264);   chk("pulse_b0_pre", {5'd0, rst_out}, 8'h07);
    at(266);   chk("pulse_b0_post", {5'd0, rst_out}, 8'h06);
    at(306);   chk("pulse_run", {6'd0, ready, rst_out[0]}, 8'h02);
    at(310);   soft_req = 1'b1;
    at(316);   chk("soft_out", {5'd0, rst_out}, 8'h07);
               chk("soft_st", {6'd0, state}, 8'h01);
               chk("soft_rdy", {7'd0, ready}, 8'h00);
    at(320);   soft_req = 1'b0;
    at(354);   chk("soft_b0_pre", {5'd0, rst_out}, 8'h07);
    at(356);   chk("soft_b0_post", {5'd0, rst_out}, 8'h06);
               chk("soft_rel_st", {6'd0, state}, 8'h02);
    at(357);   soft_req = 1'b1;
    at(361);   reset = 1'b1;
    at(361.5); chk("rel_abort_out", {5'd0, rst_out}, 8'h07);
               chk("rel_abort_st", {6'd0, state}, 8'h00);
    at(363);   reset = 1'b0;
    at(386);   chk("assert_ign_st", {6'd0, state}, 8'h01);
    at(390);   soft_req = 1'b0;
    at(398);   soft_req = 1'b1;
    at(408);   soft_req = 1'b0;
    at(436);   chk("hold_restart_st", {6'd0, state}, 8'h01);
    at(444);   chk("hold_rs_pre", {5'd0, rst_out}, 8'h07);
    at(446);   chk("hold_rs_post", {5'd0, rst_out}, 8'h06);
    at(486);   chk("final_out", {5'd0, rst_out}, 8'h00);
               chk("final_rdy", {7'd0, ready}, 8'h01);
               chk("final_st", {6'd0, state}, 8'h03);
    at(520);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
